mac_result_pack: RTL

- Output stage of the FMA/MAC datapath, directly downstream of the normalise-and-round stage.
- Applies IEEE-754 overflow and invalid result overrides to that stage's sign/exponent/mantissa and packs them into one FP word.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Accumulates RISC-V fflags (NV/DZ/OF/UF/NX) as sticky state on result retirement.

---
 rtl/mac_result_pack.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mac_result_pack.sv
// rtl/mac_result_pack.sv - FMA/MAC output stage: overflow/invalid override, FP pack, skid-buffered handshake, sticky fflags
//
// Purpose:
//   Takes the rounded sign/exponent/mantissa from the normalise-and-round stage,
//   replaces it with NaN / Inf / max-finite where the exception flags demand,
//   packs it into one FP word and presents it behind a valid/ready handshake
//   backed by a 2-entry (output + skid) buffer. Retired results fold their
//   flags into a sticky RISC-V fflags register.
//
// Ports:
//   Clk_i, Rst_n_i            clock, asynchronous active-low reset
//   Valid_i / Ready_o         upstream handshake (Ready_o is registered)
//   Sign_i, Exp_i, Mant_i     rounded result fields
//   Rounding_mode_i           RISC-V rm travelling with the result
//   Invalid_i, Overflow_i,
//   Underflow_i, Inexact_i    exception flags from rounding
//   Valid_o / Ready_i         downstream handshake
//   Result_o                  {sign, exp, mant}
//   Flags_o                   {NV,DZ,OF,UF,NX} of the current Result_o
//   Fflags_o                  sticky accumulated fflags
//   Fflags_clr_i              synchronous clear of Fflags_o
//   Exc_cnt_o                 only with MAC_EXC_CNT_EN: saturating count of
//                             retired results carrying NV/OF/UF/NX
//
// Optional feature macro: MAC_EXC_CNT_EN

module mac_result_pack #(
  parameter int                  PARM_EXP      = 8,
  parameter int                  PARM_MANT     = 23,
  parameter int                  PARM_RM       = 3,
  parameter logic [PARM_MANT-1:0] PARM_MANT_NAN = 23'h400000
) (
  input  logic                          Clk_i,
  input  logic                          Rst_n_i,
  input  logic                          Valid_i,
  output logic                          Ready_o,
  input  logic                          Sign_i,
  input  logic [PARM_EXP-1:0]           Exp_i,
  input  logic [PARM_MANT-1:0]          Mant_i,
  input  logic [PARM_RM-1:0]            Rounding_mode_i,
  input  logic                          Invalid_i,
  input  logic                          Overflow_i,
  input  logic                          Underflow_i,
  input  logic                          Inexact_i,
  output logic                          Valid_o,
  input  logic                          Ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Flags_o,
  output logic [4:0]                    Fflags_o,
`ifdef MAC_EXC_CNT_EN
  output logic [15:0]                   Exc_cnt_o,
`endif
  input  logic                          Fflags_clr_i
);

  localparam int W = PARM_EXP + PARM_MANT + 1;

  localparam logic [PARM_RM-1:0] RM_RTZ = PARM_RM'(1);
  localparam logic [PARM_RM-1:0] RM_RDN = PARM_RM'(2);
  localparam logic [PARM_RM-1:0] RM_RUP = PARM_RM'(3);

  localparam logic [PARM_EXP-1:0]  EXP_ONES  = '1;
  localparam logic [PARM_EXP-1:0]  EXP_MAXF  = {{(PARM_EXP-1){1'b1}}, 1'b0};
  localparam logic [PARM_MANT-1:0] MANT_ONES = '1;
  localparam logic [PARM_MANT-1:0] MANT_ZERO = '0;

  // ---------------- override and pack ----------------
  logic                 res_sign;
  logic [PARM_EXP-1:0]  res_exp;
  logic [PARM_MANT-1:0] res_mant;
  logic [W-1:0]         in_word;
  logic [4:0]           in_flags;

  always_comb begin
    res_sign = Sign_i;
    res_exp  = Exp_i;
    res_mant = Mant_i;
    if (Invalid_i) begin
      res_sign = 1'b0;
      res_exp  = EXP_ONES;
      res_mant = PARM_MANT_NAN;
    end else if (Overflow_i) begin
      // Default (RNE, RMM, reserved encodings) saturates to infinity.
      res_exp  = EXP_ONES;
      res_mant = MANT_ZERO;
      case (Rounding_mode_i)
        RM_RTZ: begin
          res_exp  = EXP_MAXF;
          res_mant = MANT_ONES;
        end
        RM_RDN: if (!Sign_i) begin
          res_exp  = EXP_MAXF;
          res_mant = MANT_ONES;
        end
        RM_RUP: if (Sign_i) begin
          res_exp  = EXP_MAXF;
          res_mant = MANT_ONES;
        end
        default: ;
      endcase
    end
  end

  assign in_word  = {res_sign, res_exp, res_mant};
  // An invalid result suppresses every other flag; overflow is always inexact.
  assign in_flags = {Invalid_i, 1'b0,
                     Overflow_i & ~Invalid_i,
                     Underflow_i & ~Invalid_i,
                     (Inexact_i | Overflow_i) & ~Invalid_i};

  // ---------------- output + skid buffer ----------------
  logic         out_valid, skid_valid, ready_q;
  logic [W-1:0] out_word, skid_word;
  logic [4:0]   out_flags, skid_flags, fflags_q;
  logic         accept, retire, skid_valid_nxt;

  assign accept = Valid_i & ready_q;
  assign retire = out_valid & Ready_i;

  // Skid occupancy after this edge; ready for the next cycle is derived from
  // it so Ready_o is a flop output with no path from Ready_i.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (retire || !out_valid) skid_valid_nxt = 1'b0;
    else if (accept)          skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      out_valid  <= 1'b0;
      out_word   <= '0;
      out_flags  <= '0;
      skid_valid <= 1'b0;
      skid_word  <= '0;
      skid_flags <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q    <= ~skid_valid_nxt;
      skid_valid <= skid_valid_nxt;
      if (retire || !out_valid) begin
        if (skid_valid) begin
          // Skid can only be full while the output is full, and ready was low,
          // so no new accept competes with this move.
          out_word  <= skid_word;
          out_flags <= skid_flags;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_word  <= in_word;
          out_flags <= in_flags;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_word  <= in_word;
        skid_flags <= in_flags;
      end
    end
  end

  // ---------------- sticky fflags ----------------
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      fflags_q <= '0;
    end else if (Fflags_clr_i) begin
      // Clear wipes older history but keeps the result retiring this cycle.
      fflags_q <= retire ? out_flags : 5'b0;
    end else if (retire) begin
      fflags_q <= fflags_q | out_flags;
    end
  end

`ifdef MAC_EXC_CNT_EN
  logic [15:0] exc_cnt_q;
  logic        exc_retire;

  assign exc_retire = retire & (out_flags[4] | (|out_flags[2:0]));

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      exc_cnt_q <= '0;
    end else if (Fflags_clr_i) begin
      exc_cnt_q <= {15'b0, exc_retire};
    end else if (exc_retire && exc_cnt_q != 16'hFFFF) begin
      exc_cnt_q <= exc_cnt_q + 16'd1;
    end
  end

  assign Exc_cnt_o = exc_cnt_q;
`endif

  assign Ready_o  = ready_q;
  assign Valid_o  = out_valid;
  assign Result_o = out_word;
  assign Flags_o  = out_flags;
  assign Fflags_o = fflags_q;

endmodule
